// File: rtl/instr_mem_loader.sv
// Byte-stream loader packing program bytes big-endian into 32-bit instruction-memory writes.
// Optional running checksum is built only when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
    parameter int PC_BITWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic [PC_BITWIDTH-3:0] load_base_addr,
    input  logic [PC_BITWIDTH-1:0] load_byte_count,
    input  logic                   load_abort,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   we,
    output logic [PC_BITWIDTH-3:0] wr_addr,
    output logic [31:0]            data_in,
    output logic                   busy,
    output logic                   load_done,
    output logic [7:0]             checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [PC_BITWIDTH-1:0] r_count;
    logic [1:0]             r_lane;
    logic                   w_start;
    logic                   w_accept;

    assign w_start  = (r_state == S_IDLE) && load_start;
    // An abort in the same cycle as a byte wins; the byte is dropped with the partial word.
    assign w_accept = (r_state == S_RECV) && byte_ready && byte_valid && !load_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_next = (load_byte_count == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (load_abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && ((r_lane == 2'd3) || (r_count == PC_BITWIDTH'(1)))) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (load_abort) begin
                    w_next = S_IDLE;
                end else if (r_count != '0) begin
                    w_next = S_RECV;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_lane     <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            wr_addr    <= '0;
            data_in    <= '0;
        end else begin
            r_state    <= w_next;
            byte_ready <= (w_next == S_RECV);
            we         <= (w_next == S_WRITE);
            busy       <= (w_next != S_IDLE);
            load_done  <= (w_next == S_DONE);

            if (w_start) begin
                r_count <= load_byte_count;
                wr_addr <= load_base_addr;
                r_lane  <= '0;
                data_in <= '0;
            end

            if (w_accept) begin
                r_count <= r_count - PC_BITWIDTH'(1);
                r_lane  <= r_lane + 2'd1;
                // Lane 0 clears the lower lanes so a short final word is zero-padded.
                case (r_lane)
                    2'd0:    data_in         <= {byte_data, 24'h000000};
                    2'd1:    data_in[23:16]  <= byte_data;
                    2'd2:    data_in[15:8]   <= byte_data;
                    default: data_in[7:0]    <= byte_data;
                endcase
            end

            if (r_state == S_WRITE) begin
                wr_addr <= wr_addr + (PC_BITWIDTH-2)'(1);
                r_lane  <= '0;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + byte_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (checksum expectations follow INSTR_LOADER_CHECKSUM_EN).
module tb_instr_mem_loader;
    localparam int PCW = 16;
    localparam int AW  = PCW - 2;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load_start = 1'b0;
    logic [AW-1:0]  load_base_addr = '0;
    logic [PCW-1:0] load_byte_count = '0;
    logic           load_abort = 1'b0;
    logic           byte_valid = 1'b0;
    logic [7:0]     byte_data = '0;
    logic           byte_ready;
    logic           we;
    logic [AW-1:0]  wr_addr;
    logic [31:0]    data_in;
    logic           busy;
    logic           load_done;
    logic [7:0]     checksum;

    instr_mem_loader #(.PC_BITWIDTH(PCW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_base_addr(load_base_addr), .load_byte_count(load_byte_count),
        .load_abort(load_abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .we(we), .wr_addr(wr_addr), .data_in(data_in),
        .busy(busy), .load_done(load_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int start_cyc = 0;
    logic [AW-1:0] log_addr [8];
    logic [31:0]   log_data [8];
    int            log_cyc  [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            if (we_cnt < 8) begin
                log_addr[we_cnt] = wr_addr;
                log_data[we_cnt] = data_in;
                log_cyc[we_cnt]  = cyc;
            end
            we_cnt++;
        end
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        we_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [PCW-1:0] count);
        @(posedge clk); #1;
        load_start = 1'b1;
        load_base_addr = base;
        load_byte_count = count;
        start_cyc = cyc;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout byte=%h not accepted within 20 cycles", b);
        end
    endtask

    task automatic settle();
        byte_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (data_in !== 32'h0) begin errors++; $display("FAIL reset_data_in got=%h exp=0", data_in); end
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got=%h exp=00", checksum); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_ck;
        clear_logs();
        start(14'h0010, 16'd8);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start got=%b exp=1", byte_ready); end
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        settle();
        checks++; if (we_cnt !== 2) begin errors++; $display("FAIL basic_write_count got=%0d exp=2", we_cnt); end
        checks++; if (log_addr[0] !== 14'h0010 || log_data[0] !== 32'h01020304) begin
            errors++; $display("FAIL basic_write0 got=%h@%h exp=01020304@0010", log_data[0], log_addr[0]); end
        checks++; if (log_addr[1] !== 14'h0011 || log_data[1] !== 32'h05060708) begin
            errors++; $display("FAIL basic_write1 got=%h@%h exp=05060708@0011", log_data[1], log_addr[1]); end
        checks++; if (log_cyc[1] - log_cyc[0] !== 5) begin errors++; $display("FAIL basic_throughput got=%0d exp=5 cycles", log_cyc[1] - log_cyc[0]); end
        checks++; if (done_cnt !== 1 || done_cyc !== log_cyc[1] + 1) begin
            errors++; $display("FAIL basic_done got=%0d pulses at %0d exp=1 at %0d", done_cnt, done_cyc, log_cyc[1] + 1); end
        checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=11", busy_cnt); end
        exp_ck = CK_EN ? 8'h24 : 8'h00;
        checks++; if (checksum !== exp_ck) begin errors++; $display("FAIL basic_checksum got=%h exp=%h", checksum, exp_ck); end
    endtask

    task automatic test_partial();
        logic [7:0] exp_ck;
        logic [7:0] vec [6];
        vec = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        clear_logs();
        start(14'h0100, 16'd6);
        for (int i = 0; i < 6; i++) send_byte(vec[i]);
        settle();
        checks++; if (we_cnt !== 2) begin errors++; $display("FAIL partial_write_count got=%0d exp=2", we_cnt); end
        checks++; if (log_addr[0] !== 14'h0100 || log_data[0] !== 32'hAABBCCDD) begin
            errors++; $display("FAIL partial_write0 got=%h@%h exp=AABBCCDD@0100", log_data[0], log_addr[0]); end
        checks++; if (log_addr[1] !== 14'h0101 || log_data[1] !== 32'hEEFF0000) begin
            errors++; $display("FAIL partial_write1 got=%h@%h exp=EEFF0000@0101", log_data[1], log_addr[1]); end
        // 0xAA+0xBB+0xCC+0xDD+0xEE+0xFF = 1275 = 0x4FB
        exp_ck = CK_EN ? 8'hFB : 8'h00;
        checks++; if (checksum !== exp_ck) begin errors++; $display("FAIL partial_checksum got=%h exp=%h", checksum, exp_ck); end
    endtask

    task automatic test_zero_count();
        clear_logs();
        start(14'h0200, 16'd0);
        settle();
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL zero_no_write got=%0d writes exp=0", we_cnt); end
        checks++; if (done_cnt !== 1 || done_cyc !== start_cyc + 1) begin
            errors++; $display("FAIL zero_done got=%0d pulses at %0d exp=1 at %0d", done_cnt, done_cyc, start_cyc + 1); end
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=1", busy_cnt); end
    endtask

    task automatic test_addr_wrap();
        clear_logs();
        start(14'h3FFF, 16'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
        settle();
        checks++; if (log_addr[0] !== 14'h3FFF || log_data[0] !== 32'h10111213) begin
            errors++; $display("FAIL wrap_write0 got=%h@%h exp=10111213@3FFF", log_data[0], log_addr[0]); end
        checks++; if (log_addr[1] !== 14'h0000 || log_data[1] !== 32'h14151617) begin
            errors++; $display("FAIL wrap_write1 got=%h@%h exp=14151617@0000", log_data[1], log_addr[1]); end
    endtask

    task automatic test_abort();
        clear_logs();
        start(14'h0020, 16'd4);
        send_byte(8'h31);
        send_byte(8'h32);
        byte_valid = 1'b0;
        load_abort = 1'b1;
        @(posedge clk); #1;
        load_abort = 1'b0;
        checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b ready=%b exp=0/0", busy, byte_ready); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (we_cnt !== 0 || done_cnt !== 0) begin
            errors++; $display("FAIL abort_no_write got we=%0d done=%0d exp=0/0", we_cnt, done_cnt); end
        start(14'h0030, 16'd4);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL abort_restart_ready got=%b exp=1", byte_ready); end
        for (int i = 0; i < 4; i++) send_byte(8'(8'h41 + i));
        settle();
        checks++; if (we_cnt !== 1 || log_addr[0] !== 14'h0030 || log_data[0] !== 32'h41424344) begin
            errors++; $display("FAIL abort_restart_write got=%0d writes %h@%h exp=1 41424344@0030", we_cnt, log_data[0], log_addr[0]); end
    endtask

    task automatic test_gaps_reset();
        clear_logs();
        start(14'h0040, 16'd8);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h51 + i));
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (we_cnt !== 1 || log_addr[0] !== 14'h0040 || log_data[0] !== 32'h51525354) begin
            errors++; $display("FAIL gaps_write got=%0d writes %h@%h exp=1 51525354@0040", we_cnt, log_data[0], log_addr[0]); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({we, byte_ready, busy, load_done} !== 4'b0000) begin
            errors++; $display("FAIL midreset_flags got we/ready/busy/done=%b exp=0000", {we, byte_ready, busy, load_done}); end
        checks++; if (wr_addr !== '0 || data_in !== 32'h0 || checksum !== 8'h00) begin
            errors++; $display("FAIL midreset_data got addr=%h data=%h ck=%h exp=0/0/0", wr_addr, data_in, checksum); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (we_cnt !== 1 || done_cnt !== 0) begin
            errors++; $display("FAIL midreset_spurious got we=%0d done=%0d exp=1/0", we_cnt, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero_count();
        test_addr_wrap();
        test_abort();
        test_gaps_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end
endmodule
